// File: rtl/lfsr_range_gen.sv
// lfsr_range_gen
//   Free-running Fibonacci LFSR plus a small sampler that turns LFSR states
//   into a uniformly drawn grid position (x < XMAX, y < YMAX). The sampler can
//   optionally skip one excluded cell. A request gives up after MAX_TRIES
//   rejected candidates and then delivers a clamped position with fallback=1.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   load, seed      load seed into the LFSR (zero seed -> SEED_DEFAULT)
//   req             request one position (ignored while busy)
//   excl_en         enable exclusion of cell (excl_x, excl_y), sampled live
//   rnd             current LFSR state
//   busy            sampling in progress
//   valid           one-cycle pulse when x/y/fallback are updated
//   x, y            last delivered position (held between deliveries)
//   fallback        last delivery was produced after MAX_TRIES rejects
module lfsr_range_gen #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int               XW           = 6,
  parameter int               YW           = 5,
  parameter int               XMAX         = 40,
  parameter int               YMAX         = 30,
  parameter int               MAX_TRIES    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             excl_en,
  input  logic [XW-1:0]    excl_x,
  input  logic [YW-1:0]    excl_y,
  output logic [WIDTH-1:0] rnd,
  output logic             busy,
  output logic             valid,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic             fallback
);

  // Bounds widened by one bit so XMAX == 2^XW still fits.
  localparam logic [XW:0]   XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0]   YLIM = (YW+1)'(YMAX);
  localparam logic [XW-1:0] XTOP = XW'(XMAX - 1);
  localparam logic [YW-1:0] YTOP = YW'(YMAX - 1);
  localparam int            TW   = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);

  typedef enum logic {IDLE, SAMPLE} state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             fb_q, fb_d;
  logic             valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // LFSR
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    if (load)
      lfsr_d = (seed == '0) ? SEED_DEFAULT : seed;
    else if (lfsr_q == '0)
      lfsr_d = SEED_DEFAULT;  // escape the all-zero lock-up state
  end

  // ---------------------------------------------------------------------------
  // Candidate evaluation (uses the registered state, so a load in this cycle
  // does not affect the candidate being judged)
  // ---------------------------------------------------------------------------
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          x_in, y_in, excluded, cand_ok, last_try;

  assign cx       = lfsr_q[XW-1:0];
  assign cy       = lfsr_q[XW+YW-1:XW];
  assign x_in     = {1'b0, cx} < XLIM;
  assign y_in     = {1'b0, cy} < YLIM;
  assign excluded = excl_en && (cx == excl_x) && (cy == excl_y);
  assign cand_ok  = x_in && y_in && !excluded;
  assign last_try = (tries_q == LAST);

  // ---------------------------------------------------------------------------
  // Sampler FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d    = st_q;
    tries_d = tries_q;
    x_d     = x_q;
    y_d     = y_q;
    fb_d    = fb_q;
    valid_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (req) begin
          st_d    = SAMPLE;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        if (cand_ok) begin
          x_d     = cx;
          y_d     = cy;
          fb_d    = 1'b0;
          valid_d = 1'b1;
          st_d    = IDLE;
        end else if (last_try) begin
          // Out of tries: clamp into the grid; the exclusion is not honoured.
          x_d     = x_in ? cx : XTOP;
          y_d     = y_in ? cy : YTOP;
          fb_d    = 1'b1;
          valid_d = 1'b1;
          st_d    = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= SEED_DEFAULT;
      st_q    <= IDLE;
      tries_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fb_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      st_q    <= st_d;
      tries_q <= tries_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fb_q    <= fb_d;
      valid_q <= valid_d;
    end
  end

  assign rnd      = lfsr_q;
  assign busy     = (st_q == SAMPLE);
  assign valid    = valid_q;
  assign x        = x_q;
  assign y        = y_q;
  assign fallback = fb_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
module tb_lfsr_range_gen;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS     = 16'hD008;

  logic        clk = 1'b0;
  logic        rst, load, req, excl_en;
  logic [15:0] seed;
  logic [5:0]  excl_x;
  logic [4:0]  excl_y;
  logic [15:0] rnd;
  logic        busy, valid, fallback;
  logic [5:0]  x;
  logic [4:0]  y;

  // second instance: tiny grid, fallback path
  logic        req2, excl_en2;
  logic [5:0]  excl_x2;
  logic [4:0]  excl_y2;
  logic [15:0] rnd2;
  logic        busy2, valid2, fallback2;
  logic [5:0]  x2;
  logic [4:0]  y2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_range_gen dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .req(req),
    .excl_en(excl_en), .excl_x(excl_x), .excl_y(excl_y),
    .rnd(rnd), .busy(busy), .valid(valid), .x(x), .y(y), .fallback(fallback)
  );

  lfsr_range_gen #(.XMAX(1), .YMAX(1), .MAX_TRIES(4)) dut2 (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .req(req2),
    .excl_en(excl_en2), .excl_x(excl_x2), .excl_y(excl_y2),
    .rnd(rnd2), .busy(busy2), .valid(valid2), .x(x2), .y(y2), .fallback(fallback2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the LFSR is tracked state by state; a request is resolved
  // the moment it is accepted by walking the future LFSR states until one lands
  // in the grid, giving the delivery edge and the delivered values directly.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         t;
    logic [5:0] px;
    logic [4:0] py;
    logic       pfb;
  } pred_t;

  function automatic logic [15:0] step(input logic [15:0] s);
    if (s == 16'h0) return SEED_DEF;
    return {s[14:0], ^(s & TAPS)};
  endfunction

  function automatic pred_t predict(input logic [15:0] s0, input logic en,
                                    input logic [5:0] ex, input logic [4:0] ey);
    pred_t p;
    logic [15:0] s;
    int cxi, cyi;
    s = s0;
    for (int t = 0; t < 64; t++) begin
      cxi = int'(s[5:0]);
      cyi = int'(s[10:6]);
      if (cxi < 40 && cyi < 30 && !(en && cxi == int'(ex) && cyi == int'(ey))) begin
        p.t = t; p.px = s[5:0]; p.py = s[10:6]; p.pfb = 1'b0;
        return p;
      end
      if (t == 63) begin
        p.t = t;
        p.px = (cxi < 40) ? s[5:0] : 6'd39;
        p.py = (cyi < 30) ? s[10:6] : 5'd29;
        p.pfb = 1'b1;
        return p;
      end
      s = step(s);
    end
    p.t = 0; p.px = '0; p.py = '0; p.pfb = 1'b0;
    return p;
  endfunction

  logic [15:0] m_rnd;
  logic        m_busy, m_valid, m_fb, p_fb;
  logic [5:0]  m_x, p_x;
  logic [4:0]  m_y, p_y;
  int          cyc, m_due;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rnd <= SEED_DEF; m_busy <= 1'b0; m_valid <= 1'b0;
      m_x <= '0; m_y <= '0; m_fb <= 1'b0; cyc <= 0;
    end else begin
      m_rnd   <= load ? ((seed == 16'h0) ? SEED_DEF : seed) : step(m_rnd);
      m_valid <= 1'b0;
      if (m_busy) begin
        if (cyc == m_due) begin
          m_busy <= 1'b0; m_valid <= 1'b1;
          m_x <= p_x; m_y <= p_y; m_fb <= p_fb;
        end
      end else if (req) begin
        m_busy <= 1'b1;
        m_due  <= cyc + 1 + predict(load ? ((seed == 16'h0) ? SEED_DEF : seed) : step(m_rnd),
                                    excl_en, excl_x, excl_y).t;
        p_x    <= predict(load ? ((seed == 16'h0) ? SEED_DEF : seed) : step(m_rnd),
                          excl_en, excl_x, excl_y).px;
        p_y    <= predict(load ? ((seed == 16'h0) ? SEED_DEF : seed) : step(m_rnd),
                          excl_en, excl_x, excl_y).py;
        p_fb   <= predict(load ? ((seed == 16'h0) ? SEED_DEF : seed) : step(m_rnd),
                          excl_en, excl_x, excl_y).pfb;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_rnd",      32'(rnd),      32'(m_rnd));
    chk("model_busy",     32'(busy),     32'(m_busy));
    chk("model_valid",    32'(valid),    32'(m_valid));
    chk("model_x",        32'(x),        32'(m_x));
    chk("model_y",        32'(y),        32'(m_y));
    chk("model_fallback", 32'(fallback), 32'(m_fb));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; load = 1'b0; seed = '0; req = 1'b0;
    excl_en = 1'b0; excl_x = '0; excl_y = '0;
    req2 = 1'b0; excl_en2 = 1'b1; excl_x2 = '0; excl_y2 = '0;
    repeat (2) tick();
    chk("reset_rnd", 32'(rnd), 32'hACE1);
    rst = 1'b0;

    // stepping from seed 1
    load = 1'b1; seed = 16'h0001;
    tick(); load = 1'b0;
    chk("step0", 32'(rnd), 32'h0001);
    tick(); chk("step1", 32'(rnd), 32'h0002);
    tick(); chk("step2", 32'(rnd), 32'h0004);
    tick(); chk("step3", 32'(rnd), 32'h0008);
    tick(); chk("step4", 32'(rnd), 32'h0011);

    // zero seed substitution and no lock-up
    load = 1'b1; seed = 16'h0000;
    tick(); load = 1'b0;
    chk("zero_seed", 32'(rnd), 32'hACE1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("no_lockup", 32'(rnd != 16'h0), 32'd1);
    end

    // accept on first candidate
    load = 1'b1; seed = 16'h0001;
    tick(); load = 1'b0; req = 1'b1;
    tick(); req = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_novalid", 32'(valid), 32'd0);
    tick();
    chk("acc_valid", 32'(valid), 32'd1);
    chk("acc_x", 32'(x), 32'd2);
    chk("acc_y", 32'(y), 32'd0);
    chk("acc_fb", 32'(fallback), 32'd0);
    chk("acc_busy_low", 32'(busy), 32'd0);
    tick();
    chk("acc_pulse_end", 32'(valid), 32'd0);
    chk("acc_x_hold", 32'(x), 32'd2);

    // excluded first candidate
    excl_en = 1'b1; excl_x = 6'd2; excl_y = 5'd0;
    load = 1'b1; seed = 16'h0001;
    tick(); load = 1'b0; req = 1'b1;
    tick(); req = 1'b0;
    tick();
    chk("exc_novalid", 32'(valid), 32'd0);
    chk("exc_busy", 32'(busy), 32'd1);
    tick();
    chk("exc_valid", 32'(valid), 32'd1);
    chk("exc_x", 32'(x), 32'd4);
    chk("exc_y", 32'(y), 32'd0);
    tick();
    excl_en = 1'b0;

    // back-to-back requests (req held high) from a few seeds; model checks
    load = 1'b1; seed = 16'hBEEF;
    tick(); load = 1'b0; req = 1'b1;
    repeat (40) tick();
    req = 1'b0;
    repeat (70) tick();
    excl_en = 1'b1; excl_x = 6'd17; excl_y = 5'd3;
    load = 1'b1; seed = 16'h1234;
    tick(); load = 1'b0; req = 1'b1;
    repeat (40) tick();
    req = 1'b0;
    repeat (70) tick();
    excl_en = 1'b0;

    // reset mid-SAMPLE: abandoned, no pulse
    req = 1'b1;
    tick(); req = 1'b0;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_rnd", 32'(rnd), 32'hACE1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_fb", 32'(fallback), 32'd0);
    tick(); tick();
    chk("rst_held_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rel_valid", 32'(valid), 32'd0);
    chk("rst_first_step", 32'(rnd), 32'(step(SEED_DEF)));

    // fallback instance: every candidate is out of grid or excluded
    req2 = 1'b1;
    tick(); req2 = 1'b0;
    chk("fb_busy", 32'(busy2), 32'd1);
    tick(); chk("fb_wait1", 32'(valid2), 32'd0);
    req2 = 1'b1;
    tick(); req2 = 1'b0;
    chk("fb_wait2", 32'(valid2), 32'd0);
    tick(); chk("fb_wait3", 32'(valid2), 32'd0);
    chk("fb_busy3", 32'(busy2), 32'd1);
    tick();
    chk("fb_valid", 32'(valid2), 32'd1);
    chk("fb_x", 32'(x2), 32'd0);
    chk("fb_y", 32'(y2), 32'd0);
    chk("fb_flag", 32'(fallback2), 32'd1);
    chk("fb_idle", 32'(busy2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fb_no_extra", 32'(valid2), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
